and3_vector_sequencer: RTL and testbench

Upstream stimulus and checking stage for the three-input AND gate (three_and). On a start request it drives the gate's three inputs through all 8 combinations. Each combination is held for a programmable number of cycles. On the last cycle of each hold it samples the gate output and compares it with the expected value. It reports busy/done, an error count and an overall pass flag, so the gate can be exercised on hardware with a clock rather than with testbench delays.

---
 rtl/and3_vector_sequencer.sv | 135 +++++++++++++
 tb/tb_and3_vector_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/and3_vector_sequencer.sv
// Sweeps all 8 input vectors through a 3-input AND gate and scores its output.
// Define FIRST_FAIL_CAPTURE_EN to latch the index of the first failing vector.
module and3_vector_sequencer #(
  parameter int DWELL = 10,
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic             vec_a,
  output logic             vec_b,
  output logic             vec_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state, stateNxt;
  logic [2:0]       idx, idxNxt;
  logic [CNT_W-1:0] dwell, dwellNxt;
  logic [ERR_W-1:0] errCnt, errNxt;
  logic             doneR, doneNxt;
  logic             passR, passNxt;
  logic             sampleHit;
  logic             mismatch;
  logic             accept;

  assign accept    = (state != RUN) && start;
  assign sampleHit = (state == RUN) && !abort && (dwell == LAST);
  assign mismatch  = dut_out != (&idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      dwell  <= '0;
      errCnt <= '0;
      doneR  <= 1'b0;
      passR  <= 1'b0;
    end else begin
      state  <= stateNxt;
      idx    <= idxNxt;
      dwell  <= dwellNxt;
      errCnt <= errNxt;
      doneR  <= doneNxt;
      passR  <= passNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    idxNxt   = idx;
    dwellNxt = dwell;
    errNxt   = errCnt;
    doneNxt  = doneR;
    passNxt  = passR;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNxt = RUN;
          idxNxt   = '0;
          dwellNxt = '0;
          errNxt   = '0;
          doneNxt  = 1'b0;
          passNxt  = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          stateNxt = IDLE;
          idxNxt   = '0;
          dwellNxt = '0;
        end else if (dwell == LAST) begin
          dwellNxt = '0;
          if (mismatch && (errCnt != '1))
            errNxt = errCnt + ERR_W'(1);
          if (idx == 3'd7) begin
            stateNxt = DONE;
            idxNxt   = '0;
            doneNxt  = 1'b1;
            passNxt  = (errNxt == '0);
          end else begin
            idxNxt = idx + 3'd1;
          end
        end else begin
          dwellNxt = dwell + CNT_W'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign {vec_a, vec_b, vec_c} = idx;
  assign busy    = (state == RUN);
  assign done    = doneR;
  assign pass    = passR;
  assign err_cnt = errCnt;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [2:0] failVec;
  logic       failValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      failVec   <= '0;
      failValid <= 1'b0;
    end else if (accept) begin
      failVec   <= '0;
      failValid <= 1'b0;
    end else if (sampleHit && mismatch && !failValid) begin
      failVec   <= idx;
      failValid <= 1'b1;
    end
  end

  assign fail_vec   = failVec;
  assign fail_valid = failValid;
`else
  logic unusedSig;
  assign unusedSig  = accept ^ sampleHit;
  assign fail_vec   = 3'b000;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_and3_vector_sequencer.sv
// Directed bench for and3_vector_sequencer: good, stuck-at-0/1 gates,
// abort, async reset and back-to-back DWELL=1 sweeps.
module tb_and3_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1, abort;
  int         mode;
  logic       gOut, g1Out;
  logic       a0, b0, c0, busy0, done0, pass0, fv0ok;
  logic [1:0] err0;
  logic [2:0] fvec0;
  logic       a1, b1, c1, busy1, done1, pass1, fv1ok;
  logic [3:0] err1;
  logic [2:0] fvec1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       gOut = 1'b0;
      2:       gOut = 1'b1;
      default: gOut = a0 & b0 & c0;
    endcase
  end

  assign g1Out = a1 & b1 & c1;

  and3_vector_sequencer #(.DWELL(4), .CNT_W(8), .ERR_W(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dut_out(gOut), .vec_a(a0), .vec_b(b0), .vec_c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_vec(fvec0), .fail_valid(fv0ok)
  );

  and3_vector_sequencer #(.DWELL(1), .CNT_W(8), .ERR_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .dut_out(g1Out), .vec_a(a1), .vec_b(b1), .vec_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fvec1), .fail_valid(fv1ok)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  int busyCnt;
  int k;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0; mode = 0;
    step(3);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_vec", 32'({a0, b0, c0}), 32'd0);
    check("rst_fv", 32'({fv0ok, fvec0}), 32'd0);
    rst = 1'b0;
    step(2);

    // good gate: 32 busy cycles, vec steps every 4 cycles
    mode = 0;
    kick();
    busyCnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) check("good_vec", 32'({a0, b0, c0}), 32'(i / 4));
      if (busy0) busyCnt++;
      step(1);
    end
    check("good_busy_len", 32'(busyCnt), 32'd32);
    check("good_busy_end", 32'(busy0), 32'd0);
    check("good_done", 32'(done0), 32'd1);
    check("good_pass", 32'(pass0), 32'd1);
    check("good_err", 32'(err0), 32'd0);
    check("good_vec_end", 32'({a0, b0, c0}), 32'd0);

    // stuck-at-0: only vector 7 fails
    mode = 1;
    kick();
    step(32);
    check("sa0_done", 32'(done0), 32'd1);
    check("sa0_err", 32'(err0), 32'd1);
    check("sa0_pass", 32'(pass0), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("sa0_fvec", 32'(fvec0), 32'd7);
    check("sa0_fvalid", 32'(fv0ok), 32'd1);
`else
    check("sa0_fvec", 32'(fvec0), 32'd0);
    check("sa0_fvalid", 32'(fv0ok), 32'd0);
`endif
    step(3);
    check("sa0_hold_done", 32'(done0), 32'd1);
    check("sa0_hold_err", 32'(err0), 32'd1);

    // stuck-at-1: 7 fails, saturates at 3
    mode = 2;
    kick();
    check("sa1_restart_done", 32'(done0), 32'd0);
    step(32);
    check("sa1_done", 32'(done0), 32'd1);
    check("sa1_err", 32'(err0), 32'd3);
    check("sa1_pass", 32'(pass0), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("sa1_fvec", 32'(fvec0), 32'd0);
    check("sa1_fvalid", 32'(fv0ok), 32'd1);
`else
    check("sa1_fvalid", 32'(fv0ok), 32'd0);
`endif

    // abort coincident with first sample edge discards that compare
    kick();
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abt0_busy", 32'(busy0), 32'd0);
    check("abt0_err", 32'(err0), 32'd0);
    check("abt0_done", 32'(done0), 32'd0);

    // abort at index 3, mid-dwell; partial count of 3 mismatches kept
    kick();
    step(13);
    check("abt_idx3", 32'({a0, b0, c0}), 32'd3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abt_busy", 32'(busy0), 32'd0);
    check("abt_done", 32'(done0), 32'd0);
    check("abt_vec", 32'({a0, b0, c0}), 32'd0);
    check("abt_err", 32'(err0), 32'd3);
    step(2);
    check("abt_idle_hold", 32'(busy0), 32'd0);

    // full sweep after abort
    mode = 0;
    kick();
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) busyCnt++;
      step(1);
    end
    check("post_abt_len", 32'(busyCnt), 32'd32);
    check("post_abt_pass", 32'(pass0), 32'd1);

    // async reset at index 5, start coincident with reset
    kick();
    step(21);
    check("rst5_idx", 32'({a0, b0, c0}), 32'd5);
    rst = 1'b1;
    start = 1'b1;
    #2;
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_vec", 32'({a0, b0, c0}), 32'd0);
    check("arst_done", 32'(done0), 32'd0);
    check("arst_pass", 32'(pass0), 32'd0);
    step(1);
    rst = 1'b0;
    start = 1'b0;
    step(1);
    check("arst_start_ign", 32'(busy0), 32'd0);

    // DWELL=1, start held: 8 RUN cycles then one DONE cycle, repeat
    start1 = 1'b1;
    step(1);
    for (int i = 0; i < 27; i++) begin
      k = i % 9;
      check("d1_busy", 32'(busy1), (k == 8) ? 32'd0 : 32'd1);
      check("d1_done", 32'(done1), (k == 8) ? 32'd1 : 32'd0);
      if (k == 8) check("d1_pass", 32'(pass1), 32'd1);
      else check("d1_vec", 32'({a1, b1, c1}), 32'(k));
      step(1);
    end
    start1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
